// File: rtl/mt_thread_sched.sv
// Round-robin thread scheduler with drained N-group thread-group swap.
// Optional performance counters are enabled with `define MT_SCHED_PERF_EN.
module mt_thread_sched #(
  parameter int NUM_THREADS   = 4,
  parameter int NUM_GROUPS    = 2,
  parameter int ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(0),
  parameter logic [ADDRESS_WIDTH-1:0] PC_STEP  = ADDRESS_WIDTH'(4),
  parameter int MAX_INFLIGHT  = 4,
  parameter int TID_W = $clog2(NUM_THREADS),
  parameter int GID_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
  parameter int IF_W  = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     swap_tgrp,
  input  logic [NUM_THREADS-1:0]   thread_stall,
  input  logic                     retire,
  input  logic                     upd_valid,
  input  logic [TID_W-1:0]         upd_tid,
  input  logic [ADDRESS_WIDTH-1:0] upd_pc,
  output logic                     issue_valid,
  output logic [TID_W-1:0]         issue_tid,
  output logic [ADDRESS_WIDTH-1:0] issue_pc,
  output logic [GID_W-1:0]         active_grp,
  output logic                     swap_busy
`ifdef MT_SCHED_PERF_EN
  ,
  output logic [31:0]              perf_issue_cnt,
  output logic [31:0]              perf_idle_cnt,
  output logic [15:0]              perf_swap_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;

  state_t                   state_r, state_nxt_s;
  logic [ADDRESS_WIDTH-1:0] pc_r [0:NUM_GROUPS-1][0:NUM_THREADS-1];
  logic [TID_W-1:0]         ptr_r;
  logic [IF_W-1:0]          inflight_r, inflight_nxt_s;
  logic [TID_W-1:0]         sel_s, cand_s;
  logic                     found_s, do_issue_s, ret_eff_s;

  // Round-robin pick: scan from the farthest candidate back so the nearest eligible thread wins.
  always_comb begin
    found_s = |(~thread_stall);
    sel_s   = '0;
    cand_s  = '0;
    for (int k = NUM_THREADS; k >= 1; k--) begin
      cand_s = ptr_r + TID_W'(k);
      sel_s  = thread_stall[cand_s] ? sel_s : cand_s;
    end
  end

  // Next-state, issue qualification and in-flight accounting.
  always_comb begin
    state_nxt_s = state_r;
    do_issue_s  = 1'b0;
    ret_eff_s   = retire && (inflight_r != '0);
    case (state_r)
      ST_RUN: begin
        do_issue_s  = !swap_tgrp && found_s && (inflight_r < IF_W'(MAX_INFLIGHT));
        state_nxt_s = swap_tgrp ? ST_DRAIN : ST_RUN;
      end
      ST_DRAIN: begin
        // Leaves when the count reaches zero this cycle, including via a final retire.
        state_nxt_s = (inflight_r == IF_W'(ret_eff_s)) ? ST_SWAP : ST_DRAIN;
      end
      ST_SWAP:  state_nxt_s = ST_RUN;
      default:  state_nxt_s = ST_RUN;
    endcase
    inflight_nxt_s = inflight_r + IF_W'(do_issue_s) - IF_W'(ret_eff_s);
  end

  // Scheduler state, PC file and registered issue outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_RUN;
      active_grp  <= '0;
      ptr_r       <= TID_W'(NUM_THREADS - 1);
      inflight_r  <= '0;
      issue_valid <= 1'b0;
      issue_tid   <= '0;
      issue_pc    <= RESET_PC;
      swap_busy   <= 1'b0;
      for (int g = 0; g < NUM_GROUPS; g++) begin
        for (int t = 0; t < NUM_THREADS; t++) begin
          pc_r[g][t] <= RESET_PC;
        end
      end
    end else begin
      state_r     <= state_nxt_s;
      inflight_r  <= inflight_nxt_s;
      issue_valid <= do_issue_s;
      swap_busy   <= (state_nxt_s != ST_RUN);
      if (do_issue_s) begin
        issue_tid               <= sel_s;
        issue_pc                <= pc_r[active_grp][sel_s];
        ptr_r                   <= sel_s;
        pc_r[active_grp][sel_s] <= pc_r[active_grp][sel_s] + PC_STEP;
      end
      // Placed after the increment so a same-thread redirect overrides it.
      if (upd_valid) begin
        pc_r[active_grp][upd_tid] <= upd_pc;
      end
      if (state_r == ST_SWAP) begin
        active_grp <= (active_grp == GID_W'(NUM_GROUPS - 1)) ? '0 : active_grp + GID_W'(1);
        ptr_r      <= TID_W'(NUM_THREADS - 1);
      end
    end
  end

`ifdef MT_SCHED_PERF_EN
  // Issue (wrapping), idle-RUN (saturating) and completed-swap (wrapping) counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_issue_cnt <= 32'd0;
      perf_idle_cnt  <= 32'd0;
      perf_swap_cnt  <= 16'd0;
    end else begin
      if (do_issue_s) begin
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      end
      if ((state_r == ST_RUN) && !do_issue_s && (perf_idle_cnt != 32'hFFFF_FFFF)) begin
        perf_idle_cnt <= perf_idle_cnt + 32'd1;
      end
      if (state_r == ST_SWAP) begin
        perf_swap_cnt <= perf_swap_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mt_thread_sched.sv
// Bench for mt_thread_sched: directed vector table, reset-in-drain sequence,
// then randomized traffic checked against a behavioural model.
module tb_mt_thread_sched;
  localparam int NT   = 4;
  localparam int NG   = 2;
  localparam int MAXI = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        swap_tgrp = 1'b0;
  logic [3:0]  thread_stall = 4'b0000;
  logic        retire = 1'b0;
  logic        upd_valid = 1'b0;
  logic [1:0]  upd_tid = 2'd0;
  logic [31:0] upd_pc = 32'd0;
  logic        issue_valid;
  logic [1:0]  issue_tid;
  logic [31:0] issue_pc;
  logic [0:0]  active_grp;
  logic        swap_busy;
`ifdef MT_SCHED_PERF_EN
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_idle_cnt;
  logic [15:0] perf_swap_cnt;
`endif

  mt_thread_sched dut (
    .clk(clk), .rst(rst), .swap_tgrp(swap_tgrp), .thread_stall(thread_stall),
    .retire(retire), .upd_valid(upd_valid), .upd_tid(upd_tid), .upd_pc(upd_pc),
    .issue_valid(issue_valid), .issue_tid(issue_tid), .issue_pc(issue_pc),
    .active_grp(active_grp), .swap_busy(swap_busy)
`ifdef MT_SCHED_PERF_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_idle_cnt(perf_idle_cnt),
    .perf_swap_cnt(perf_swap_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: PC table, last issued thread, outstanding count, mode 0=run 1=drain 2=swap.
  logic [31:0] m_pc [NG][NT];
  int          m_last, m_infl, m_mode, m_grp;
  logic        e_valid;
  logic [1:0]  e_tid;
  logic [31:0] e_pc;

  typedef struct {
    logic [3:0]  st;
    logic        sw, rt, uv;
    logic [1:0]  ut;
    logic [31:0] up;
    logic        ev;
    logic [1:0]  et;
    logic [31:0] ep;
    logic        eg, eb;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < NG; g++)
      for (int t = 0; t < NT; t++) m_pc[g][t] = 32'd0;
    m_last = NT - 1; m_infl = 0; m_mode = 0; m_grp = 0;
    e_valid = 1'b0; e_tid = 2'd0; e_pc = 32'd0;
  endtask

  task automatic model_step(input logic [3:0] st, input logic sw, input logic rt,
                            input logic uv, input logic [1:0] ut, input logic [31:0] up);
    int  old;
    int  t;
    bit  iss;
    old = m_infl;
    iss = 1'b0;
    if (m_mode == 0 && !sw && m_infl < MAXI) begin
      for (int k = 1; k <= NT; k++) begin
        t = (m_last + k) % NT;
        if (!iss && !st[t]) begin
          iss = 1'b1;
          e_tid = t[1:0];
          e_pc = m_pc[m_grp][t];
          m_pc[m_grp][t] = m_pc[m_grp][t] + 32'd4;
          m_last = t;
        end
      end
    end
    e_valid = iss;
    if (uv) m_pc[m_grp][ut] = up;
    if (iss) m_infl++;
    if (rt && old > 0) m_infl--;
    case (m_mode)
      0: if (sw) m_mode = 1;
      1: if (m_infl == 0) m_mode = 2;
      default: begin
        m_grp = (m_grp + 1) % NG;
        m_last = NT - 1;
        m_mode = 0;
      end
    endcase
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".valid"}, {31'd0, issue_valid}, {31'd0, e_valid});
    chk({tag, ".grp"}, {31'd0, active_grp}, m_grp);
    chk({tag, ".busy"}, {31'd0, swap_busy}, {31'd0, m_mode != 0});
    if (e_valid) begin
      chk({tag, ".tid"}, {30'd0, issue_tid}, {30'd0, e_tid});
      chk({tag, ".pc"}, issue_pc, e_pc);
    end
  endtask

  task automatic apply(input logic [3:0] st, input logic sw, input logic rt,
                       input logic uv, input logic [1:0] ut, input logic [31:0] up);
    thread_stall = st; swap_tgrp = sw; retire = rt;
    upd_valid = uv; upd_tid = ut; upd_pc = up;
    model_step(st, sw, rt, uv, ut, up);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    swap_tgrp = 1'($urandom_range(0, 1)); retire = 1'($urandom_range(0, 1));
    upd_valid = 1'b1; upd_tid = 2'($urandom); upd_pc = $urandom;
    thread_stall = 4'b0000;
    @(posedge clk); #1;
    model_reset();
    chk({tag, ".rst_valid"}, {31'd0, issue_valid}, 32'd0);
    chk({tag, ".rst_tid"}, {30'd0, issue_tid}, 32'd0);
    chk({tag, ".rst_pc"}, issue_pc, 32'd0);
    chk({tag, ".rst_grp"}, {31'd0, active_grp}, 32'd0);
    chk({tag, ".rst_busy"}, {31'd0, swap_busy}, 32'd0);
`ifdef MT_SCHED_PERF_EN
    chk({tag, ".rst_perf_issue"}, perf_issue_cnt, 32'd0);
    chk({tag, ".rst_perf_idle"}, perf_idle_cnt, 32'd0);
    chk({tag, ".rst_perf_swap"}, {16'd0, perf_swap_cnt}, 32'd0);
`endif
    rst = 1'b1; upd_valid = 1'b0;
  endtask

  task automatic add(input logic [3:0] st, input logic sw, input logic rt, input logic uv,
                     input logic [1:0] ut, input logic [31:0] up, input logic ev,
                     input logic [1:0] et, input logic [31:0] ep, input logic eg, input logic eb);
    vec_t v;
    v.st = st; v.sw = sw; v.rt = rt; v.uv = uv; v.ut = ut; v.up = up;
    v.ev = ev; v.et = et; v.ep = ep; v.eg = eg; v.eb = eb;
    tbl.push_back(v);
  endtask

  initial begin
    // Directed table: round robin, stall mask, inflight limit, two swaps, redirect race.
    for (int i = 0; i < 8; i++) add(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'(i % 4), 32'(4 * (i / 4)), 1'b0, 1'b0);
    add(4'b0101, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 32'd8,  1'b0, 1'b0);
    add(4'b0101, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'd3, 32'd8,  1'b0, 1'b0);
    add(4'b0101, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 32'd12, 1'b0, 1'b0);
    add(4'b1111, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0,  1'b0, 1'b0);
    add(4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0,  1'b0, 1'b0);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd2, 32'd8,  1'b0, 1'b0);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd3, 32'd12, 1'b0, 1'b0);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd0, 32'd8,  1'b0, 1'b0);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 32'd16, 1'b0, 1'b0);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0,  1'b0, 1'b0);
    add(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0,  1'b0, 1'b0);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd2, 32'd12, 1'b0, 1'b0);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0,  1'b0, 1'b0);
    add(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0,  1'b0, 1'b0);
    add(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0,  1'b0, 1'b1);
    add(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0,  1'b0, 1'b1);
    add(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0,  1'b0, 1'b1);
    add(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0,  1'b0, 1'b1);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0,  1'b1, 1'b0);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, 2'd0, 32'd0,  1'b1, 1'b0);
    add(4'b0000, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 32'd0,  1'b1, 1'b0);
    add(4'b0000, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0,  1'b1, 1'b1);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0,  1'b1, 1'b1);
    add(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0,  1'b0, 1'b0);
    add(4'b1011, 1'b0, 1'b0, 1'b1, 2'd2, 32'h100, 1'b1, 2'd2, 32'd16, 1'b0, 1'b0);
    add(4'b1011, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 2'd2, 32'h100, 1'b0, 1'b0);

    @(posedge clk); #1;
    do_reset("init");

    foreach (tbl[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      apply(tbl[i].st, tbl[i].sw, tbl[i].rt, tbl[i].uv, tbl[i].ut, tbl[i].up);
      chk({nm, ".valid"}, {31'd0, issue_valid}, {31'd0, tbl[i].ev});
      chk({nm, ".grp"}, {31'd0, active_grp}, {31'd0, tbl[i].eg});
      chk({nm, ".busy"}, {31'd0, swap_busy}, {31'd0, tbl[i].eb});
      if (tbl[i].ev) begin
        chk({nm, ".tid"}, {30'd0, issue_tid}, {30'd0, tbl[i].et});
        chk({nm, ".pc"}, issue_pc, tbl[i].ep);
      end
    end

    // Reset while draining: everything discarded, four fresh issues at PC 0, then limit.
    apply(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0); cmp_model("pre_drain");
    apply(4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0); cmp_model("enter_drain");
    apply(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 32'h40); cmp_model("in_drain");
    do_reset("drain");
    for (int i = 0; i < 5; i++) begin
      apply(4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
      cmp_model($sformatf("post_rst%0d", i));
    end

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] st;
      if ($urandom_range(0, 599) == 0) begin
        do_reset($sformatf("rnd_rst%0d", i));
      end else begin
        st = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
        apply(st, ($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), 2'($urandom), {$urandom_range(0, 255), 2'b00} & 32'h3FC);
        cmp_model($sformatf("rnd%0d", i));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
